// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared definitions for the ADC capture path. Used by the capture
//   controller and the readout block so both agree on state encoding.
//
//   CNT_W_DEFAULT : default width of capture length / sample counter
//   state_t       : one-hot controller state (IDLE/BUFFER/DRAIN/STOP)
package capture_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned NUM_CH_DEFAULT = 2;

    // One-hot so readout logic can test a single bit per state.
    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StBuffer = 4'b0010,
        StDrain  = 4'b0100,
        StStop   = 4'b1000
    } state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if
//   Bundles the control, FIFO-status and FIFO-write signals of the capture
//   controller.
//
//   master : the capture controller (drives wr_en and status)
//   slave  : host / FIFO side (drives requests and FIFO flags)
//
//   start, abort, mode, capture_len, ch_en : capture request and setup
//   fifo_rst, full, empty                  : FIFO status
//   wr_en                                  : per-FIFO write enables
//   busy, done, overflow, sample_cnt, state: controller status
interface capture_ctrl_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16
) ();
    import capture_pkg::*;

    logic              start;
    logic              abort;
    logic              mode;
    logic [CNT_W-1:0]  capture_len;
    logic [NUM_CH-1:0] ch_en;
    logic              fifo_rst;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] wr_en;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CNT_W-1:0]  sample_cnt;
    state_t            state;

    modport master (
        input  start,
        input  abort,
        input  mode,
        input  capture_len,
        input  ch_en,
        input  fifo_rst,
        input  full,
        input  empty,
        output wr_en,
        output busy,
        output done,
        output overflow,
        output sample_cnt,
        output state
    );

    modport slave (
        output start,
        output abort,
        output mode,
        output capture_len,
        output ch_en,
        output fifo_rst,
        output full,
        output empty,
        input  wr_en,
        input  busy,
        input  done,
        input  overflow,
        input  sample_cnt,
        input  state
    );

endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl
//   Multi-channel capture controller between the ADC sample stream and the
//   per-channel capture FIFOs. Arms on start, writes capture_len samples into
//   every enabled FIFO in lock-step, waits for all enabled FIFOs to drain,
//   then re-arms (continuous mode) or returns to idle.
//
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : capture_ctrl_if.master (requests, FIFO flags, wr_en, status)
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rstn,
    capture_ctrl_if.master bus
);

    state_t            state_q;
    logic [NUM_CH-1:0] ch_en_q;
    logic [CNT_W-1:0]  len_q;
    logic              mode_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic              overflow_q;
    logic              done_q;

    logic              any_full;
    logic              all_empty;
    logic              arm;
    logic [NUM_CH-1:0] wr_en;
    logic              wr_active;
    logic              last_write;

    always_comb begin
        // Disabled channels are masked out of both full and empty.
        any_full  = |(bus.full & ch_en_q);
        all_empty = &(bus.empty | ~ch_en_q);
        arm       = bus.start && !bus.fifo_rst &&
                    (bus.capture_len != '0) && (bus.ch_en != '0);

        // Zero latency from full so no write is issued into a full FIFO.
        wr_en = '0;
        if ((state_q == StBuffer) && !any_full) begin
            wr_en = ch_en_q;
        end
        wr_active  = |wr_en;
        // Stopping on len_q-1 keeps sample_cnt <= len_q, so it cannot wrap
        // even at a full-scale length.
        last_write = wr_active && (sample_cnt_q == len_q - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            ch_en_q      <= '0;
            len_q        <= '0;
            mode_q       <= 1'b0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Writes issued this cycle always count, even when leaving BUFFER
            // on abort or fifo_rst.
            if (wr_active) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        ch_en_q      <= bus.ch_en;
                        len_q        <= bus.capture_len;
                        mode_q       <= bus.mode;
                        sample_cnt_q <= '0;
                        overflow_q   <= 1'b0;
                        state_q      <= StBuffer;
                    end
                end

                StBuffer: begin
                    if (bus.fifo_rst) begin
                        state_q <= StIdle;
                    end else if (bus.abort) begin
                        state_q <= StStop;
                    end else if (any_full) begin
                        overflow_q <= 1'b1;
                        state_q    <= StDrain;
                    end else if (last_write) begin
                        state_q <= StDrain;
                    end
                end

                StDrain: begin
                    if (bus.fifo_rst) begin
                        state_q <= StIdle;
                    end else if (bus.abort) begin
                        state_q <= StStop;
                    end else if (all_empty) begin
                        done_q <= 1'b1;
                        // An overflowed capture is never repeated.
                        if (mode_q && !overflow_q) begin
                            sample_cnt_q <= '0;
                            state_q      <= StBuffer;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end

                StStop: begin
                    if (bus.fifo_rst) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl
//   Directed bench for capture_ctrl (NUM_CH=2, CNT_W=16). Expected writes
//   (enable vector + count before the write) and done pulses are queued when
//   stimulus is applied and popped by a negedge monitor when the DUT acts.
module tb_capture_ctrl;
    import capture_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 16;

    logic clk;
    logic rstn;

    capture_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    capture_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] wr;
        logic [CW-1:0]  cnt;
    } wr_exp_t;

    wr_exp_t wq[$];
    int      dq[$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write and every done pulse must have been predicted.
    always @(negedge clk) begin
        wr_exp_t e;
        if (bus.wr_en !== '0) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(bus.wr_en), 32'(0));
            end else begin
                e = wq.pop_front();
                check("write_enables", 32'(bus.wr_en), 32'(e.wr));
                check("write_count", 32'(bus.sample_cnt), 32'(e.cnt));
            end
        end
        if (bus.done === 1'b1) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        rstn            = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.mode        = 1'b0;
        bus.capture_len = '0;
        bus.ch_en       = '0;
        bus.fifo_rst    = 1'b0;
        bus.full        = '0;
        bus.empty       = '0;
        cyc(2);
        check("rst_state", 32'(bus.state), 32'(4'b0001));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_overflow", 32'(bus.overflow), 32'(0));
        check("rst_cnt", 32'(bus.sample_cnt), 32'(0));
        rstn = 1'b1;
        cyc(1);

        // Single-shot, 8 samples on both channels.
        bus.ch_en = 2'b11; bus.capture_len = 16'd8; bus.mode = 1'b0;
        for (int i = 0; i < 8; i++) wq.push_back('{wr: 2'b11, cnt: CW'(i)});
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("t1_buffer", 32'(bus.state), 32'(4'b0010));
        check("t1_busy", 32'(bus.busy), 32'(1));
        cyc(8);
        check("t1_drain", 32'(bus.state), 32'(4'b0100));
        check("t1_cnt", 32'(bus.sample_cnt), 32'(8));
        cyc(3);
        check("t1_hold_drain", 32'(bus.state), 32'(4'b0100));
        check("t1_writes_left", 32'(wq.size()), 32'(0));
        bus.empty = 2'b11;
        dq.push_back(1);
        cyc(1);
        check("t1_done", 32'(bus.done), 32'(1));
        check("t1_idle", 32'(bus.state), 32'(4'b0001));
        check("t1_not_busy", 32'(bus.busy), 32'(0));
        cyc(1);
        check("t1_done_pulse", 32'(bus.done), 32'(0));

        // Overflow after 40 of 100 writes; continuous mode must not re-arm.
        bus.empty = 2'b00; bus.capture_len = 16'd100; bus.mode = 1'b1;
        for (int i = 0; i < 40; i++) wq.push_back('{wr: 2'b11, cnt: CW'(i)});
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(40);
        bus.full = 2'b10;
        #1;
        check("t2_wr_suppressed", 32'(bus.wr_en), 32'(0));
        cyc(1);
        check("t2_drain", 32'(bus.state), 32'(4'b0100));
        check("t2_overflow", 32'(bus.overflow), 32'(1));
        check("t2_cnt", 32'(bus.sample_cnt), 32'(40));
        bus.full = 2'b00; bus.empty = 2'b11;
        dq.push_back(2);
        cyc(1);
        check("t2_done", 32'(bus.done), 32'(1));
        check("t2_idle", 32'(bus.state), 32'(4'b0001));
        check("t2_overflow_sticky", 32'(bus.overflow), 32'(1));

        // Continuous, 4 samples, channel 0 only; channel 1 flags ignored.
        bus.ch_en = 2'b01; bus.capture_len = 16'd4; bus.mode = 1'b1;
        bus.empty = 2'b01; bus.full = 2'b10;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 4; i++) wq.push_back('{wr: 2'b01, cnt: CW'(i)});
        dq.push_back(3); dq.push_back(3);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("t3_overflow_cleared", 32'(bus.overflow), 32'(0));
        check("t3_buffer", 32'(bus.state), 32'(4'b0010));
        cyc(14);
        check("t3_third_drain", 32'(bus.state), 32'(4'b0100));
        check("t3_cnt", 32'(bus.sample_cnt), 32'(4));
        bus.fifo_rst = 1'b1;
        cyc(1);
        bus.fifo_rst = 1'b0; bus.full = 2'b00;
        check("t3_idle", 32'(bus.state), 32'(4'b0001));
        check("t3_no_done", 32'(bus.done), 32'(0));
        check("t3_writes_left", 32'(wq.size()), 32'(0));
        check("t3_dones_left", 32'(dq.size()), 32'(0));

        // Abort during write 3 of 10.
        bus.ch_en = 2'b11; bus.capture_len = 16'd10; bus.mode = 1'b0; bus.empty = 2'b00;
        for (int i = 0; i < 3; i++) wq.push_back('{wr: 2'b11, cnt: CW'(i)});
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        check("t4_stop", 32'(bus.state), 32'(4'b1000));
        check("t4_wr_off", 32'(bus.wr_en), 32'(0));
        check("t4_cnt", 32'(bus.sample_cnt), 32'(3));
        cyc(3);
        check("t4_stop_held", 32'(bus.state), 32'(4'b1000));
        check("t4_cnt_held", 32'(bus.sample_cnt), 32'(3));
        check("t4_busy", 32'(bus.busy), 32'(1));
        bus.fifo_rst = 1'b1;
        cyc(1);
        bus.fifo_rst = 1'b0;
        check("t4_idle", 32'(bus.state), 32'(4'b0001));

        // Illegal arm attempts.
        bus.capture_len = 16'd0; bus.ch_en = 2'b11; bus.start = 1'b1;
        cyc(3);
        check("t5_len_zero", 32'(bus.state), 32'(4'b0001));
        bus.capture_len = 16'd8; bus.ch_en = 2'b00;
        cyc(3);
        check("t5_no_channel", 32'(bus.state), 32'(4'b0001));
        bus.ch_en = 2'b11; bus.fifo_rst = 1'b1;
        cyc(3);
        check("t5_fifo_rst", 32'(bus.state), 32'(4'b0001));
        bus.start = 1'b0; bus.fifo_rst = 1'b0;
        cyc(1);

        // Length 1 on channel 1 only; empty[0] ignored.
        bus.ch_en = 2'b10; bus.capture_len = 16'd1; bus.mode = 1'b0; bus.empty = 2'b00;
        wq.push_back('{wr: 2'b10, cnt: CW'(0)});
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
        check("t7_drain", 32'(bus.state), 32'(4'b0100));
        check("t7_cnt", 32'(bus.sample_cnt), 32'(1));
        bus.empty = 2'b10;
        dq.push_back(7);
        cyc(1);
        check("t7_done", 32'(bus.done), 32'(1));
        check("t7_idle", 32'(bus.state), 32'(4'b0001));

        // Reset in the middle of a capture.
        bus.ch_en = 2'b11; bus.capture_len = 16'd20; bus.empty = 2'b00;
        for (int i = 0; i < 5; i++) wq.push_back('{wr: 2'b11, cnt: CW'(i)});
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(4);
        rstn = 1'b0;
        cyc(1);
        check("t6_state", 32'(bus.state), 32'(4'b0001));
        check("t6_busy", 32'(bus.busy), 32'(0));
        check("t6_wr_en", 32'(bus.wr_en), 32'(0));
        check("t6_cnt", 32'(bus.sample_cnt), 32'(0));
        check("t6_overflow", 32'(bus.overflow), 32'(0));
        check("t6_done", 32'(bus.done), 32'(0));
        rstn = 1'b1;
        cyc(2);
        check("end_writes_left", 32'(wq.size()), 32'(0));
        check("end_dones_left", 32'(dq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
